hazard_ctrl_param: RTL and testbench
====================================

Name: hazard_ctrl_param

Overview:
- Parametrised hazard/forwarding controller for the pipelined core (IF, ID, EX, MEM, WB).
- Generalises the fixed 16-bit hazard unit with:
  - configurable register-address width;
  - an explicit load-use interlock;
  - a branch-flush FSM with programmable flush depth and stop-freeze semantics;
  - store-data forwarding;
  - saturating performance counters.
- Sits beside the pipeline registers and drives their stall/flush enables and the EX/MEM operand muxes.

Parameters:
- REG_AW, 4, register address width; register 0 is hardwired zero and never forwarded or interlocked.
- BR_FLUSH_CYC, 3, cycles flush_ex_mem stays asserted after a taken branch (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_id, rt_id  in  REG_AW  source regs of instruction in ID
- rs_ex, rt_ex  in  REG_AW  source regs of instruction in EX
- rd_ex  in  REG_AW  destination of instruction in EX
- memread_ex  in  1  EX instruction is a load
- rt_mem  in  REG_AW  store-data reg of instruction in MEM
- memwrite_mem  in  1  MEM instruction is a store
- rd_mem, regwrite_mem  in  REG_AW, 1  MEM destination / write enable
- rd_wb, regwrite_wb  in  REG_AW, 1  WB destination / write enable
- stop  in  1  global freeze request (memory busy)
- jump  in  1  jump decoded in ID
- branch_taken  in  1  branch resolved taken in EX
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- fwd_st  out  1  store data from WB result
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold enables
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  bubble insert
- flush_busy  out  1  branch FSM in FLUSH
- stall_count, flush_count  out  CNT_W each  saturating event counters

Behaviour:
- Reset:
  - rst is synchronous and active-high; clk is the clock.
  - On a rst cycle: FSM is IDLE, down-counter is 0, both performance counters are 0.
  - All stall/flush/fwd outputs are 0 in the rst cycle and the cycle after.
  - rst mid-flush aborts the flush immediately.
- Forwarding (combinational, zero latency):
  - fwd_a = 01 if regwrite_mem && rd_mem!=0 && rd_mem==rs_ex.
  - Otherwise fwd_a = 10 if regwrite_wb && rd_wb!=0 && rd_wb==rs_ex.
  - Otherwise fwd_a = 00. MEM has priority over WB.
  - fwd_b: same rules using rt_ex.
  - fwd_st = memwrite_mem && regwrite_wb && rd_wb!=0 && rd_wb==rt_mem.
  - Forwarding outputs are independent of stop.
- Load-use interlock:
  - luse = memread_ex && rd_ex!=0 && (rd_ex==rs_id || rd_ex==rt_id).
  - Effect: pc_stall=1, if_id_stall=1, flush_id_ex=1 for exactly that cycle. Interlock lasts one cycle because the load advances to MEM.
- Branch FSM, states IDLE and FLUSH:
  - IDLE→FLUSH on branch_taken && !stop. Counter loads BR_FLUSH_CYC-1.
  - In the transition cycle, flush_if_id=1 and flush_id_ex=1 (wrong-path instructions in IF/ID are discarded).
  - In FLUSH: flush_ex_mem=1 and flush_busy=1; counter decrements each non-stop cycle; FLUSH→IDLE when counter==0.
  - branch_taken while in FLUSH re-arms the counter to BR_FLUSH_CYC-1 and re-asserts flush_if_id/flush_id_ex.
  - BR_FLUSH_CYC=1: FLUSH lasts exactly one cycle.
- Jump:
  - jump && !luse && !stop → flush_if_id=1 for one cycle. Jump does not enter the FSM.
  - jump during luse is suppressed; the jump stays in ID and is re-evaluated next cycle.
- Priority, highest first: rst > stop > branch_taken > luse > jump.
  - stop=1: all five *_stall=1, all flush_*=0, FSM state and counter frozen, counters do not increment.
  - branch_taken with luse in the same cycle: the branch flush wins; the luse stall is dropped because the ID instruction is killed.
- Performance counters:
  - stall_count increments on each cycle with pc_stall=1.
  - flush_count increments on each IDLE→FLUSH or re-arm event.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Back-to-back ALU dependence, REG_AW=4: rd_mem=3/regwrite_mem=1, rd_wb=3/regwrite_wb=1, rs_ex=3 → fwd_a=01. With rs_ex=0 → fwd_a=00.
- Load-use: memread_ex=1, rd_ex=5, rt_id=5 → one cycle of pc_stall=1, if_id_stall=1, flush_id_ex=1; stall_count=1; next cycle all 0.
- Taken branch, BR_FLUSH_CYC=3: branch_taken pulse at cycle t →
  - flush_if_id/flush_id_ex=1 at t;
  - flush_ex_mem=1 and flush_busy=1 for cycles t+1..t+3, then 0;
  - flush_count=1.
- stop held 2 cycles mid-flush (after first FLUSH cycle) → all stalls=1, flushes=0 during stop; flush_ex_mem resumes and FLUSH lasts 2 more cycles.
- Simultaneous events:
  - branch_taken+luse+jump in the same cycle → only the branch flush is asserted, stall_count unchanged.
  - rst asserted in the second FLUSH cycle → next cycle flush_busy=0 and counters=0.
- Saturation, CNT_W=4: hold luse for 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use interlock, branch flush FSM, jump flush and saturating event counters.
module hazard_ctrl_param #(
    parameter int REG_AW       = 4,
    parameter int BR_FLUSH_CYC = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rt_mem,
    input  logic              memwrite_mem,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              regwrite_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwrite_wb,
    input  logic              stop,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_st,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              mem_wb_stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              flush_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0] RELOAD = 3'(BR_FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [CNT_W-1:0] fc_q, fc_d;
    logic             rst_dly_q, rst_dly_d;

    logic hold, act, luse, in_flush;
    logic br_ev, luse_ev, jump_ev, stall_all;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (regwrite_mem && (|rd_mem) && rd_mem == src)
            return 2'b01;
        if (regwrite_wb && (|rd_wb) && rd_wb == src)
            return 2'b10;
        return 2'b00;
    endfunction

    // Outputs stay quiet in the reset cycle and the one after it.
    assign hold     = rst | rst_dly_q;
    assign act      = !hold && !stop;
    assign in_flush = (state_q == FLUSH);

    assign luse = memread_ex && (|rd_ex)
               && (rd_ex == rs_id || rd_ex == rt_id);

    // A taken branch kills the ID instruction, so it overrides luse and jump.
    assign br_ev     = act && branch_taken;
    assign luse_ev   = act && !branch_taken && luse;
    assign jump_ev   = act && !branch_taken && !luse && jump;
    assign stall_all = !hold && stop;

    assign fwd_a  = hold ? 2'b00 : fwd_sel(rs_ex);
    assign fwd_b  = hold ? 2'b00 : fwd_sel(rt_ex);
    assign fwd_st = !hold && memwrite_mem && regwrite_wb
                 && (|rd_wb) && rd_wb == rt_mem;

    assign pc_stall     = stall_all | luse_ev;
    assign if_id_stall  = stall_all | luse_ev;
    assign id_ex_stall  = stall_all;
    assign ex_mem_stall = stall_all;
    assign mem_wb_stall = stall_all;

    assign flush_if_id  = br_ev | jump_ev;
    assign flush_id_ex  = br_ev | luse_ev;
    assign flush_ex_mem = act && in_flush;
    assign flush_busy   = !hold && in_flush;

    assign stall_count = rst ? '0 : sc_q;
    assign flush_count = rst ? '0 : fc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sc_d      = sc_q;
        fc_d      = fc_q;
        rst_dly_d = rst;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
            sc_d    = '0;
            fc_d    = '0;
        end else begin
            if (br_ev) begin
                state_d = FLUSH;
                cnt_d   = RELOAD;
                if (fc_q != '1)
                    fc_d = fc_q + CNT_W'(1);
            end else if (act && in_flush) begin
                if (cnt_q == 3'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            if (luse_ev && sc_q != '1)
                sc_d = sc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        sc_q      <= sc_d;
        fc_q      <= fc_d;
        rst_dly_q <= rst_dly_d;
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: a default instance and a CNT_W=4/BR_FLUSH_CYC=1
// instance share stimulus and are checked every cycle against a rule model.
module tb_hazard_ctrl_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rt_mem, rd_mem, rd_wb;
    logic       memread_ex, memwrite_mem, regwrite_mem, regwrite_wb;
    logic       stop, jump, branch_taken;

    logic [1:0]  m_fwd_a, m_fwd_b, s_fwd_a, s_fwd_b;
    logic        m_fwd_st, m_pc_stall, m_if_id_stall, m_id_ex_stall;
    logic        m_ex_mem_stall, m_mem_wb_stall, m_flush_if_id;
    logic        m_flush_id_ex, m_flush_ex_mem, m_flush_busy;
    logic        s_fwd_st, s_pc_stall, s_if_id_stall, s_id_ex_stall;
    logic        s_ex_mem_stall, s_mem_wb_stall, s_flush_if_id;
    logic        s_flush_id_ex, s_flush_ex_mem, s_flush_busy;
    logic [15:0] m_stall_count, m_flush_count;
    logic [3:0]  s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_param u_main (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rd_ex(rd_ex), .memread_ex(memread_ex),
        .rt_mem(rt_mem), .memwrite_mem(memwrite_mem),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .stop(stop), .jump(jump), .branch_taken(branch_taken),
        .fwd_a(m_fwd_a), .fwd_b(m_fwd_b), .fwd_st(m_fwd_st),
        .pc_stall(m_pc_stall), .if_id_stall(m_if_id_stall),
        .id_ex_stall(m_id_ex_stall), .ex_mem_stall(m_ex_mem_stall),
        .mem_wb_stall(m_mem_wb_stall),
        .flush_if_id(m_flush_if_id), .flush_id_ex(m_flush_id_ex),
        .flush_ex_mem(m_flush_ex_mem), .flush_busy(m_flush_busy),
        .stall_count(m_stall_count), .flush_count(m_flush_count)
    );

    hazard_ctrl_param #(.REG_AW(4), .BR_FLUSH_CYC(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rd_ex(rd_ex), .memread_ex(memread_ex),
        .rt_mem(rt_mem), .memwrite_mem(memwrite_mem),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .stop(stop), .jump(jump), .branch_taken(branch_taken),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_st(s_fwd_st),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
        .id_ex_stall(s_id_ex_stall), .ex_mem_stall(s_ex_mem_stall),
        .mem_wb_stall(s_mem_wb_stall),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .flush_ex_mem(s_flush_ex_mem), .flush_busy(s_flush_busy),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    logic [13:0] m_vec, s_vec;
    assign m_vec = {m_fwd_a, m_fwd_b, m_fwd_st, m_pc_stall, m_if_id_stall,
                    m_id_ex_stall, m_ex_mem_stall, m_mem_wb_stall,
                    m_flush_if_id, m_flush_id_ex, m_flush_ex_mem,
                    m_flush_busy};
    assign s_vec = {s_fwd_a, s_fwd_b, s_fwd_st, s_pc_stall, s_if_id_stall,
                    s_id_ex_stall, s_ex_mem_stall, s_mem_wb_stall,
                    s_flush_if_id, s_flush_id_ex, s_flush_ex_mem,
                    s_flush_busy};

    task automatic chk(input string name, input longint got,
                       input longint want);
        n_checks++;
        if (got == want)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h (t=%0t)",
                     name, got, want, $time);
    endtask

    // Model: flush_left = FLUSH cycles still owed; counts are plain integers.
    int br_cyc[2] = '{3, 1};
    int cmax[2]   = '{65535, 15};
    int flush_left[2];
    int sc[2];
    int fc[2];
    bit prev_rst = 1'b0;

    function automatic logic [1:0] m_fwd(input logic [3:0] src);
        if (regwrite_mem && rd_mem != 0 && rd_mem == src) return 2'b01;
        if (regwrite_wb && rd_wb != 0 && rd_wb == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_out(input int i);
        logic [1:0] fa, fb;
        logic fs, ps, st, fif, fie, fem, busy, lu;
        fa = '0; fb = '0; fs = 0; ps = 0; st = 0;
        fif = 0; fie = 0; fem = 0; busy = 0;
        if (!(rst || prev_rst)) begin
            lu = memread_ex && rd_ex != 0
              && (rd_ex == rs_id || rd_ex == rt_id);
            fa = m_fwd(rs_ex);
            fb = m_fwd(rt_ex);
            fs = memwrite_mem && regwrite_wb && rd_wb != 0
              && rd_wb == rt_mem;
            busy = flush_left[i] > 0;
            if (stop) begin
                ps = 1; st = 1;
            end else begin
                fem = busy;
                if (branch_taken) begin
                    fif = 1; fie = 1;
                end else if (lu) begin
                    ps = 1; fie = 1;
                end else if (jump) begin
                    fif = 1;
                end
            end
        end
        return {fa, fb, fs, ps, ps, st, st, st, fif, fie, fem, busy};
    endfunction

    always @(negedge clk) begin
        logic lu;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("outs%0d", i), i == 0 ? m_vec : s_vec,
                model_out(i));
            chk($sformatf("stall_count%0d", i),
                i == 0 ? m_stall_count : s_stall_count,
                rst ? 0 : sc[i]);
            chk($sformatf("flush_count%0d", i),
                i == 0 ? m_flush_count : s_flush_count,
                rst ? 0 : fc[i]);
        end
        lu = memread_ex && rd_ex != 0 && (rd_ex == rs_id || rd_ex == rt_id);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                flush_left[i] = 0; sc[i] = 0; fc[i] = 0;
            end else if (!prev_rst && !stop) begin
                if (branch_taken) begin
                    flush_left[i] = br_cyc[i];
                    if (fc[i] < cmax[i]) fc[i]++;
                end else if (flush_left[i] > 0) begin
                    flush_left[i]--;
                end
                if (lu && !branch_taken && sc[i] < cmax[i]) sc[i]++;
            end
        end
        prev_rst = rst;
    end

    task automatic clr();
        rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0;
        rt_mem = 0; rd_mem = 0; rd_wb = 0;
        memread_ex = 0; memwrite_mem = 0; regwrite_mem = 0; regwrite_wb = 0;
        stop = 0; jump = 0; branch_taken = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1;
        rd_mem = 3; regwrite_mem = 1; rs_ex = 3;
        @(negedge clk);
        chk("rst_fwd_a", m_fwd_a, 0);
        chk("rst_stall_count", m_stall_count, 0);
        nxt();
        nxt();
        rst = 0;
        @(negedge clk);
        chk("postrst_fwd_a", m_fwd_a, 0);
        nxt();
        rd_wb = 3; regwrite_wb = 1;
        @(negedge clk);
        chk("fwd_mem_prio", m_fwd_a, 2'b01);
        nxt();
        rs_ex = 0;
        @(negedge clk);
        chk("fwd_rs0", m_fwd_a, 2'b00);
        nxt();
        regwrite_mem = 0; rs_ex = 3; rt_ex = 3;
        @(negedge clk);
        chk("fwd_wb_a", m_fwd_a, 2'b10);
        chk("fwd_wb_b", m_fwd_b, 2'b10);
        nxt();
        memwrite_mem = 1; rt_mem = 3; stop = 1;
        @(negedge clk);
        chk("fwd_st", m_fwd_st, 1);
        chk("fwd_under_stop", m_fwd_a, 2'b10);
        chk("stop_mem_wb_stall", m_mem_wb_stall, 1);
        nxt();
        rd_wb = 0; rt_mem = 0; stop = 0;
        @(negedge clk);
        chk("fwd_st_r0", m_fwd_st, 0);
        nxt();
        clr();

        memread_ex = 1; rd_ex = 5; rt_id = 5;
        @(negedge clk);
        chk("luse_pc_stall", m_pc_stall, 1);
        chk("luse_if_id_stall", m_if_id_stall, 1);
        chk("luse_flush_id_ex", m_flush_id_ex, 1);
        nxt();
        clr();
        @(negedge clk);
        chk("luse_count", m_stall_count, 1);
        chk("luse_released", m_pc_stall, 0);
        nxt();
        memread_ex = 1;
        @(negedge clk);
        chk("luse_r0", m_pc_stall, 0);
        nxt();
        clr();

        branch_taken = 1;
        @(negedge clk);
        chk("br_flush_if_id", m_flush_if_id, 1);
        chk("br_flush_id_ex", m_flush_id_ex, 1);
        chk("br_flush_ex_mem", m_flush_ex_mem, 0);
        nxt();
        clr();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("br_fem_t%0d", k), m_flush_ex_mem, 1);
            chk($sformatf("br_busy_t%0d", k), m_flush_busy, 1);
            chk($sformatf("br1_busy_t%0d", k), s_flush_busy, k == 1);
            nxt();
        end
        @(negedge clk);
        chk("br_done_fem", m_flush_ex_mem, 0);
        chk("br_done_busy", m_flush_busy, 0);
        chk("br_flush_count", m_flush_count, 1);
        nxt();

        branch_taken = 1;
        nxt();
        clr();
        @(negedge clk);
        chk("stopflush_t1", m_flush_ex_mem, 1);
        nxt();
        stop = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stop_no_fem", m_flush_ex_mem, 0);
            chk("stop_pc_stall", m_pc_stall, 1);
            chk("stop_busy", m_flush_busy, 1);
            nxt();
        end
        stop = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("resume_fem", m_flush_ex_mem, 1);
            nxt();
        end
        @(negedge clk);
        chk("resume_done", m_flush_busy, 0);
        chk("stop_flush_count", m_flush_count, 2);
        chk("stop_not_counted", m_stall_count, 1);
        nxt();

        branch_taken = 1; jump = 1;
        memread_ex = 1; rd_ex = 5; rs_id = 5;
        @(negedge clk);
        chk("all3_flush_if_id", m_flush_if_id, 1);
        chk("all3_flush_id_ex", m_flush_id_ex, 1);
        chk("all3_no_stall", m_pc_stall, 0);
        nxt();
        clr();
        @(negedge clk);
        chk("all3_stall_count", m_stall_count, 1);
        chk("all3_flush_count", m_flush_count, 3);
        repeat (3) nxt();
        jump = 1;
        @(negedge clk);
        chk("jump_if_id", m_flush_if_id, 1);
        chk("jump_no_id_ex", m_flush_id_ex, 0);
        nxt();
        memread_ex = 1; rd_ex = 6; rt_id = 6;
        @(negedge clk);
        chk("jump_luse_sup", m_flush_if_id, 0);
        chk("jump_luse_stall", m_pc_stall, 1);
        nxt();
        clr();
        @(negedge clk);
        chk("jump_luse_count", m_stall_count, 2);
        nxt();

        branch_taken = 1;
        nxt();
        clr();
        nxt();
        branch_taken = 1;
        @(negedge clk);
        chk("rearm_fem", m_flush_ex_mem, 1);
        chk("rearm_if_id", m_flush_if_id, 1);
        nxt();
        clr();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rearm_busy", m_flush_busy, 1);
            nxt();
        end
        @(negedge clk);
        chk("rearm_done", m_flush_busy, 0);
        chk("rearm_count", m_flush_count, 5);
        nxt();

        branch_taken = 1;
        nxt();
        clr();
        nxt();
        rst = 1;
        @(negedge clk);
        chk("rst_abort_busy", m_flush_busy, 0);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("after_rst_busy", m_flush_busy, 0);
        chk("after_rst_sc", m_stall_count, 0);
        chk("after_rst_fc", m_flush_count, 0);
        nxt();

        memread_ex = 1; rd_ex = 5; rs_id = 5;
        repeat (20) nxt();
        clr();
        @(negedge clk);
        chk("sat_small", s_stall_count, 15);
        chk("sat_main", m_stall_count, 20);
        nxt();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
